// File: rtl/date_pkg.sv
// Shared calendar constants, state encoding and leap-year rule for the date <-> POSIX paths.
package date_pkg;

    localparam int unsigned FIRST_YEAR = 1970;
    localparam int unsigned LAST_YEAR  = 2106;
    localparam int unsigned SEC_IN_DAY = 86400;
    localparam int unsigned MONTH_CNT  = 12;
    localparam int unsigned DAYS_W     = 17;

    localparam logic [4:0] DAYS_JAN      = 5'd31;
    localparam logic [4:0] DAYS_FEB      = 5'd28;
    localparam logic [4:0] DAYS_FEB_LEAP = 5'd29;
    localparam logic [4:0] DAYS_MAR      = 5'd31;
    localparam logic [4:0] DAYS_APR      = 5'd30;
    localparam logic [4:0] DAYS_MAY      = 5'd31;
    localparam logic [4:0] DAYS_JUN      = 5'd30;
    localparam logic [4:0] DAYS_JUL      = 5'd31;
    localparam logic [4:0] DAYS_AUG      = 5'd31;
    localparam logic [4:0] DAYS_SEP      = 5'd30;
    localparam logic [4:0] DAYS_OCT      = 5'd31;
    localparam logic [4:0] DAYS_NOV      = 5'd30;
    localparam logic [4:0] DAYS_DEC      = 5'd31;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        YEARS,
        MONTHS,
        COMBINE,
        DONE
    } d2p_state_t;

    // Gregorian rule: every 4th year, except centuries not divisible by 400.
    function automatic logic leap_year(input logic [15:0] year);
        return (((year % 16'd4) == 16'd0) && ((year % 16'd100) != 16'd0)) ||
               ((year % 16'd400) == 16'd0);
    endfunction

endpackage

// File: rtl/month_days_lut.sv
// Number of days in a 0-based month; out-of-range months return 0.
module month_days_lut
    import date_pkg::*;
(
    input  logic [3:0] month_i,
    input  logic       leap_i,
    output logic [4:0] days_c
);

    always_comb begin
        days_c = 5'd0;
        case (month_i)
            4'd0:    days_c = DAYS_JAN;
            4'd1:    days_c = leap_i ? DAYS_FEB_LEAP : DAYS_FEB;
            4'd2:    days_c = DAYS_MAR;
            4'd3:    days_c = DAYS_APR;
            4'd4:    days_c = DAYS_MAY;
            4'd5:    days_c = DAYS_JUN;
            4'd6:    days_c = DAYS_JUL;
            4'd7:    days_c = DAYS_AUG;
            4'd8:    days_c = DAYS_SEP;
            4'd9:    days_c = DAYS_OCT;
            4'd10:   days_c = DAYS_NOV;
            4'd11:   days_c = DAYS_DEC;
            default: days_c = 5'd0;
        endcase
    end

endmodule

// File: rtl/date_to_posix_time.sv
// Iterative calendar-date to POSIX-seconds converter (one year or one month per cycle).
module date_to_posix_time #(
    parameter int unsigned FIRST_YEAR = 1970,
    parameter int unsigned MAX_YEAR   = 3000,
    localparam int unsigned YEAR_W    = $clog2(MAX_YEAR)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [YEAR_W-1:0] year_i,
    input  logic [3:0]        month_i,
    input  logic [4:0]        day_in_month_i,
    input  logic [4:0]        hour_i,
    input  logic [5:0]        min_i,
    input  logic [5:0]        sec_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       posix_time_o
);
    import date_pkg::*;

    d2p_state_t         state_q, state_d;
    logic [YEAR_W-1:0]  year_q, cur_year_q;
    logic [3:0]         month_q, cur_mon_q;
    logic [4:0]         day_q, hour_q;
    logic [5:0]         min_q, sec_q;
    logic [DAYS_W-1:0]  days_acc_q;
    logic               err_q;

    logic               leap_c, cur_leap_c, field_err_c, res_err_c;
    logic [3:0]         lut_month_c;
    logic [4:0]         lut_days_c;
    logic [32:0]        total_c;
    logic               busy_d, done_d, err_d;
    logic [31:0]        posix_d;

    assign leap_c      = leap_year(16'(year_q));
    assign cur_leap_c  = leap_year(16'(cur_year_q));
    assign lut_month_c = (state_q == MONTHS) ? cur_mon_q : month_q;

    month_days_lut u_month_days_lut (
        .month_i (lut_month_c),
        .leap_i  (leap_c),
        .days_c  (lut_days_c)
    );

    // Years past LAST_YEAR cannot fit in 32 bits; rejecting them also bounds the YEARS loop.
    assign field_err_c = (year_q < YEAR_W'(FIRST_YEAR)) || (year_q > YEAR_W'(LAST_YEAR)) ||
                         (month_q >= 4'(MONTH_CNT)) || (hour_q > 5'd23) ||
                         (min_q > 6'd59) || (sec_q > 6'd59) || (day_q >= lut_days_c);

    assign total_c = (33'(days_acc_q) + 33'(day_q)) * 33'(SEC_IN_DAY) +
                     33'(hour_q) * 33'd3600 + 33'(min_q) * 33'd60 + 33'(sec_q);
    assign res_err_c = err_q | total_c[32];

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; rejected requests still pass COMBINE so they finish in a fixed 2 cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = CHECK;
            CHECK:   state_d = field_err_c ? COMBINE : YEARS;
            YEARS:   if (cur_year_q == year_q) state_d = MONTHS;
            MONTHS:  if (cur_mon_q == month_q) state_d = COMBINE;
            COMBINE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: results are loaded on the edge that enters DONE
    always_comb begin
        busy_d  = busy_o;
        done_d  = 1'b0;
        err_d   = err_o;
        posix_d = posix_time_o;
        if (state_q == IDLE && start_i) begin
            busy_d = 1'b1;
        end
        if (state_q == COMBINE) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = res_err_c;
            posix_d = res_err_c ? 32'd0 : total_c[31:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            posix_time_o <= 32'd0;
        end else begin
            busy_o       <= busy_d;
            done_o       <= done_d;
            err_o        <= err_d;
            posix_time_o <= posix_d;
        end
    end

    // Latched request and the year/month day accumulator
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            year_q     <= '0;
            month_q    <= '0;
            day_q      <= '0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            cur_year_q <= '0;
            cur_mon_q  <= '0;
            days_acc_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    year_q     <= year_i;
                    month_q    <= month_i;
                    day_q      <= day_in_month_i;
                    hour_q     <= hour_i;
                    min_q      <= min_i;
                    sec_q      <= sec_i;
                    cur_year_q <= YEAR_W'(FIRST_YEAR);
                    cur_mon_q  <= 4'd0;
                    days_acc_q <= '0;
                    err_q      <= 1'b0;
                end
                CHECK:  err_q <= field_err_c;
                YEARS:  if (cur_year_q != year_q) begin
                    days_acc_q <= days_acc_q + (cur_leap_c ? DAYS_W'(366) : DAYS_W'(365));
                    cur_year_q <= cur_year_q + YEAR_W'(1);
                end
                MONTHS: if (cur_mon_q != month_q) begin
                    days_acc_q <= days_acc_q + DAYS_W'(lut_days_c);
                    cur_mon_q  <= cur_mon_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_date_to_posix_time.sv
// Scoreboarded random/directed bench for date_to_posix_time against a closed-form civil-date model.
module tb_date_to_posix_time;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [11:0] year_i;
    logic [3:0]  month_i;
    logic [4:0]  day_in_month_i;
    logic [4:0]  hour_i;
    logic [5:0]  min_i;
    logic [5:0]  sec_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] posix_time_o;

    date_to_posix_time dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .year_i         (year_i),
        .month_i        (month_i),
        .day_in_month_i (day_in_month_i),
        .hour_i         (hour_i),
        .min_i          (min_i),
        .sec_i          (sec_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .posix_time_o   (posix_time_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit      err;
        longint  t;
        int      lat;
        int      acc;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     done_cnt = 0;
    bit     last_err = 1'b0;
    longint last_t = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Days since 1970-01-01 for a 1-based month/day (Hinnant's era formula)
    function automatic longint days_from_civil(input longint y0, input longint m, input longint d);
        longint y, era, yoe, mp, doy, doe;
        y   = (m <= 2) ? y0 - 1 : y0;
        era = y / 400;
        yoe = y - era * 400;
        mp  = (m > 2) ? m - 3 : m + 9;
        doy = (153 * mp + 2) / 5 + d - 1;
        doe = yoe * 365 + yoe / 4 - yoe / 100 + doy;
        return era * 146097 + doe - 719468;
    endfunction

    task automatic model(input int y, input int m, input int d, input int h, input int mi,
                         input int s, output bit err, output longint t, output int lat);
        int  mdays[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        bit  leap;
        int  dim;
        bit  ferr;
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        dim  = (m >= 0 && m < 12) ? mdays[m] + ((m == 1 && leap) ? 1 : 0) : 0;
        ferr = (y < 1970) || (y > 2106) || (m > 11) || (h > 23) || (mi > 59) || (s > 59) ||
               (d >= dim);
        t = 0;
        if (!ferr)
            t = days_from_civil(y, m + 1, d + 1) * 86400 + h * 3600 + mi * 60 + s;
        err = ferr || (t > 64'h0000_0000_FFFF_FFFF);
        if (err) t = 0;
        lat = ferr ? 2 : 2 + (y - 1970 + 1) + (m + 1);
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding request
    always @(negedge clk_i) begin
        if (!rst_i && done_o) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1, expected no pending request (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("done_err", longint'(err_o), longint'(e.err));
                check("done_time", longint'(posix_time_o), e.t);
                check("latency", longint'(cyc - e.acc), longint'(e.lat));
                check("busy_at_done", longint'(busy_o), 0);
            end
        end
    end

    task automatic issue(input int y, input int m, input int d, input int h, input int mi, input int s);
        bit     e;
        longint t;
        int     lat;
        int     n;
        n = 0;
        while ((busy_o || done_o) && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", n);
        end
        check("held_err", longint'(err_o), longint'(last_err));
        check("held_time", longint'(posix_time_o), last_t);
        model(y, m, d, h, mi, s, e, t, lat);
        year_i         = 12'(y);
        month_i        = 4'(m);
        day_in_month_i = 5'(d);
        hour_i         = 5'(h);
        min_i          = 6'(mi);
        sec_i          = 6'(s);
        start_i        = 1'b1;
        sb.push_back('{err: e, t: t, lat: lat, acc: cyc + 1});
        last_err = e;
        last_t   = t;
        @(negedge clk_i);
        start_i = 1'b0;
        check("busy_after_accept", longint'(busy_o), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, longint'(busy_o), 0);
        check({tag, "_done"}, longint'(done_o), 0);
        check({tag, "_err"}, longint'(err_o), 0);
        check({tag, "_time"}, longint'(posix_time_o), 0);
    endtask

    initial begin
        int d0;
        int n;
        rst_i = 1'b1;
        start_i = 1'b0;
        year_i = '0;
        month_i = '0;
        day_in_month_i = '0;
        hour_i = '0;
        min_i = '0;
        sec_i = '0;
        repeat (3) @(negedge clk_i);
        check_outputs_zero("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        // Directed: epoch, century leap, leap day, 32-bit limit and field errors
        issue(1970, 0, 0, 0, 0, 0);
        issue(2000, 2, 0, 0, 0, 0);
        issue(2024, 1, 28, 12, 34, 56);
        issue(2023, 1, 28, 12, 34, 56);
        issue(2106, 1, 6, 6, 28, 15);
        issue(2106, 1, 6, 6, 28, 16);
        issue(2107, 1, 6, 6, 28, 15);
        issue(2024, 12, 0, 0, 0, 0);
        issue(2024, 0, 0, 24, 0, 0);
        issue(2024, 0, 0, 0, 60, 0);
        issue(2024, 0, 0, 0, 0, 60);
        issue(1969, 11, 30, 23, 59, 59);
        issue(2099, 11, 30, 23, 59, 59);
        issue(2100, 1, 28, 0, 0, 0);
        issue(2024, 3, 30, 0, 0, 0);

        // Start while busy is ignored: exactly one done with the 2024 result
        issue(2024, 1, 28, 12, 34, 56);
        repeat (3) @(negedge clk_i);
        year_i  = 12'd1970;
        month_i = 4'd0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;

        // Reset in the middle of the YEARS walk
        issue(2024, 5, 10, 1, 2, 3);
        repeat (10) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_outputs_zero("midreset");
        sb.delete();
        last_err = 1'b0;
        last_t   = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        d0 = done_cnt;
        repeat (100) @(negedge clk_i);
        check("no_done_after_reset", longint'(done_cnt - d0), 0);
        issue(2024, 1, 28, 12, 34, 56);

        // Randomized requests, mostly in range with occasional bad fields
        for (int i = 0; i < 60; i++) begin
            int y, m, d, h, mi, s;
            y  = int'($urandom_range(2110, 1968));
            m  = ($urandom_range(9, 0) == 0) ? int'($urandom_range(15, 12)) : int'($urandom_range(11, 0));
            d  = int'($urandom_range(31, 0));
            h  = ($urandom_range(9, 0) == 0) ? int'($urandom_range(31, 24)) : int'($urandom_range(23, 0));
            mi = ($urandom_range(9, 0) == 0) ? int'($urandom_range(63, 60)) : int'($urandom_range(59, 0));
            s  = ($urandom_range(9, 0) == 0) ? int'($urandom_range(63, 60)) : int'($urandom_range(59, 0));
            issue(y, m, d, h, mi, s);
        end

        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
        end
        repeat (5) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
